// File: rtl/wb_queue.sv
// Writeback queue: buffers register-file writes, drains one per cycle into the
// single RF write port, and forwards pending values to the two decode read ports.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    input  logic                     hold,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_wa,
    output logic [DW-1:0]            rf_wd,
    input  logic [AW-1:0]            ra1,
    input  logic [AW-1:0]            ra2,
    output logic                     byp1_hit,
    output logic [DW-1:0]            byp1_data,
    output logic                     byp2_hit,
    output logic [DW-1:0]            byp2_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] q_addr [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          push, pop;

    // Ready looks only at occupancy, so hold never reaches in_ready combinationally.
    assign in_ready = (count != CW'(DEPTH));
    // Writes to $zero complete the handshake but are dropped here.
    assign push     = in_valid & in_ready & (in_addr != '0);
    assign pop      = (count != '0) & ~hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            rf_we  <= 1'b0;
            rf_wa  <= '0;
            rf_wd  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            rf_we <= pop;
            if (pop) begin
                rf_wa <= q_addr[rd_ptr];
                rf_wd <= q_data[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= in_addr;
            q_data[wr_ptr] <= in_data;
        end
    end

    logic [1:0][AW-1:0] ra_v;
    logic [1:0]         hit;
    logic [1:0][DW-1:0] dat;

    // Scan oldest to newest so the newest match overrides; the output register
    // is older than any FIFO entry since the RF has not committed it yet.
    always_comb begin
        ra_v = {ra2, ra1};
        hit  = '0;
        dat  = '0;
        for (int p = 0; p < 2; p++) begin
            if (ra_v[p] != '0) begin
                if (rf_we && rf_wa == ra_v[p]) begin
                    hit[p] = 1'b1;
                    dat[p] = rf_wd;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) < count && q_addr[rd_ptr + PW'(i)] == ra_v[p]) begin
                        hit[p] = 1'b1;
                        dat[p] = q_data[rd_ptr + PW'(i)];
                    end
                end
            end
        end
    end

    assign byp1_hit  = hit[0];
    assign byp1_data = dat[0];
    assign byp2_hit  = hit[1];
    assign byp2_data = dat[1];

endmodule
